// File: rtl/fire_expand3_ifm_reader_pkg.sv
// Shared constants, reader state encoding and a width helper for the
// expand-3x3 input feature-map reader.
package fire_pkg;

  localparam int WIDTH        = 16;
  localparam int CHIN         = 16;
  localparam int KERNEL_DIM   = 3;
  localparam int PAD          = 1;
  localparam int TAPS         = KERNEL_DIM * KERNEL_DIM * CHIN;
  localparam int FLUSH_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    GAP   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } reader_state_e;

  // Counter width for a range of 'value' states; never narrower than one bit
  // so degenerate ranges still produce a legal vector.
  function automatic int clog2_min1(input int value);
    int result;
    if (value <= 2) begin
      result = 1;
    end else begin
      result = $clog2(value);
    end
    return result;
  endfunction

endpackage

// File: rtl/fire_expand3_ifm_reader_window_counter.sv
// Nested window walker: ch innermost, then kx, ky, ox, oy. Each advance
// steps one tap; after the very last tap of the frame every counter returns
// to zero so the next frame starts from pixel (0,0), tap 0.
module fmap_window_counter #(
  parameter int W_IN       = 64,
  parameter int CHIN       = 16,
  parameter int KERNEL_DIM = 3,
  parameter int CH_W       = fire_pkg::clog2_min1(CHIN),
  parameter int K_W        = fire_pkg::clog2_min1(KERNEL_DIM),
  parameter int P_W        = fire_pkg::clog2_min1(W_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            advance,
  output logic [CH_W-1:0] ch,
  output logic [K_W-1:0]  kx,
  output logic [K_W-1:0]  ky,
  output logic [P_W-1:0]  ox,
  output logic [P_W-1:0]  oy,
  output logic            last_tap,
  output logic            last_pixel
);

  logic ch_last_s;
  logic kx_last_s;
  logic ky_last_s;
  logic ox_last_s;
  logic oy_last_s;

  // Terminal-value detection for every level of the nest.
  always_comb begin
    ch_last_s  = (ch == CH_W'(CHIN - 1));
    kx_last_s  = (kx == K_W'(KERNEL_DIM - 1));
    ky_last_s  = (ky == K_W'(KERNEL_DIM - 1));
    ox_last_s  = (ox == P_W'(W_IN - 1));
    oy_last_s  = (oy == P_W'(W_IN - 1));
    last_tap   = ch_last_s && kx_last_s && ky_last_s;
    last_pixel = ox_last_s && oy_last_s;
  end

  // Carry-chained counters; an inner level wrapping steps the next level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch <= '0;
      kx <= '0;
      ky <= '0;
      ox <= '0;
      oy <= '0;
    end else if (clr) begin
      ch <= '0;
      kx <= '0;
      ky <= '0;
      ox <= '0;
      oy <= '0;
    end else if (advance) begin
      if (!ch_last_s) begin
        ch <= ch + CH_W'(1);
      end else begin
        ch <= '0;
        if (!kx_last_s) begin
          kx <= kx + K_W'(1);
        end else begin
          kx <= '0;
          if (!ky_last_s) begin
            ky <= ky + K_W'(1);
          end else begin
            ky <= '0;
            if (!ox_last_s) begin
              ox <= ox + P_W'(1);
            end else begin
              ox <= '0;
              if (!oy_last_s) begin
                oy <= oy + P_W'(1);
              end else begin
                oy <= '0;
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/fire_expand3_ifm_reader.sv
// Feature-map reader for the expand-3x3 MAC array. Issues one RAM read per
// tap in window order, substitutes zeros for the pad-1 border, and presents
// activations with a continuous layer enable: TAPS taps plus GAP_CYCLES
// clear slots per output pixel.
module fire_expand3_ifm_reader #(
  parameter int W_IN       = 64,
  parameter int CHIN       = fire_pkg::CHIN,
  parameter int KERNEL_DIM = fire_pkg::KERNEL_DIM,
  parameter int WIDTH      = fire_pkg::WIDTH,
  parameter int GAP_CYCLES = 1,
  parameter int ADDR_W     = $clog2(W_IN * W_IN * CHIN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              ram_rd_en_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  input  logic [WIDTH-1:0]  ram_data_i,
  output logic              layer_en_o,
  output logic [WIDTH-1:0]  ifm_o,
  output logic              busy_o,
  output logic              done_o
);

  import fire_pkg::*;

  localparam int CH_W  = clog2_min1(CHIN);
  localparam int K_W   = clog2_min1(KERNEL_DIM);
  localparam int P_W   = clog2_min1(W_IN);
  // Two spare bits so that "coordinate minus pad" wraps far above W_IN and
  // a single unsigned compare catches both borders.
  localparam int C_W   = P_W + 2;
  localparam int GAP_W = clog2_min1(GAP_CYCLES);

  reader_state_e state_r;
  reader_state_e state_next;

  logic [GAP_W-1:0] gap_cnt_r;
  logic             flush_cnt_r;
  logic             last_frame_r;

  logic             issue_s;
  logic             gap_slot_s;
  logic             set_last_s;
  logic             cnt_clr_s;

  logic [CH_W-1:0]  ch_s;
  logic [K_W-1:0]   kx_s;
  logic [K_W-1:0]   ky_s;
  logic [P_W-1:0]   ox_s;
  logic [P_W-1:0]   oy_s;
  logic             last_tap_s;
  logic             last_pixel_s;

  logic [C_W-1:0]    iy_s;
  logic [C_W-1:0]    ix_s;
  logic              in_bounds_s;
  logic [ADDR_W-1:0] addr_s;

  logic tap1_r;
  logic pad1_r;
  logic vld1_r;
  logic tap2_r;
  logic pad2_r;
  logic vld2_r;

  fmap_window_counter #(
    .W_IN       (W_IN),
    .CHIN       (CHIN),
    .KERNEL_DIM (KERNEL_DIM),
    .CH_W       (CH_W),
    .K_W        (K_W),
    .P_W        (P_W)
  ) u_window_counter (
    .clk        (clk),
    .rst        (rst),
    .clr        (cnt_clr_s),
    .advance    (issue_s),
    .ch         (ch_s),
    .kx         (kx_s),
    .ky         (ky_s),
    .ox         (ox_s),
    .oy         (oy_s),
    .last_tap   (last_tap_s),
    .last_pixel (last_pixel_s)
  );

  // Input coordinate, border test and linear RAM address of the current tap.
  always_comb begin
    iy_s        = C_W'(oy_s) + C_W'(ky_s) - C_W'(PAD);
    ix_s        = C_W'(ox_s) + C_W'(kx_s) - C_W'(PAD);
    in_bounds_s = (iy_s < C_W'(W_IN)) && (ix_s < C_W'(W_IN));
    addr_s      = ((ADDR_W'(iy_s[P_W-1:0]) * ADDR_W'(W_IN)
                  + ADDR_W'(ix_s[P_W-1:0])) * ADDR_W'(CHIN))
                  + ADDR_W'(ch_s);
  end

  // Next-state and per-cycle slot decisions. A tap is issued on the start
  // edge itself so the first address is visible the cycle after start.
  always_comb begin
    state_next = state_r;
    issue_s    = 1'b0;
    gap_slot_s = 1'b0;
    set_last_s = 1'b0;
    cnt_clr_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          issue_s    = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        issue_s = 1'b1;
        if (last_tap_s) begin
          set_last_s = last_pixel_s;
          state_next = GAP;
        end else begin
          state_next = RUN;
        end
      end
      GAP: begin
        gap_slot_s = 1'b1;
        if (gap_cnt_r == GAP_W'(GAP_CYCLES - 1)) begin
          if (last_frame_r) begin
            state_next = FLUSH;
          end else begin
            state_next = RUN;
          end
        end else begin
          state_next = GAP;
        end
      end
      FLUSH: begin
        if (flush_cnt_r == 1'(FLUSH_CYCLES - 1)) begin
          state_next = DONE;
        end else begin
          state_next = FLUSH;
        end
      end
      DONE: begin
        cnt_clr_s  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register plus gap/flush slot counters and the last-window marker.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      gap_cnt_r    <= '0;
      flush_cnt_r  <= 1'b0;
      last_frame_r <= 1'b0;
    end else begin
      state_r <= state_next;
      if ((state_r == GAP) && (state_next == GAP)) begin
        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
      end else begin
        gap_cnt_r <= '0;
      end
      if ((state_r == FLUSH) && (state_next == FLUSH)) begin
        flush_cnt_r <= flush_cnt_r + 1'b1;
      end else begin
        flush_cnt_r <= 1'b0;
      end
      if (set_last_s) begin
        last_frame_r <= 1'b1;
      end else if (state_r == DONE) begin
        last_frame_r <= 1'b0;
      end else begin
        last_frame_r <= last_frame_r;
      end
    end
  end

  // RAM request register; the address is held across padded taps and gaps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_rd_en_o <= 1'b0;
      ram_addr_o  <= '0;
    end else begin
      ram_rd_en_o <= issue_s && in_bounds_s;
      if (issue_s && in_bounds_s) begin
        ram_addr_o <= addr_s;
      end else begin
        ram_addr_o <= ram_addr_o;
      end
    end
  end

  // Slot/tap/pad flags travelling alongside the RAM access latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap1_r <= 1'b0;
      pad1_r <= 1'b0;
      vld1_r <= 1'b0;
      tap2_r <= 1'b0;
      pad2_r <= 1'b0;
      vld2_r <= 1'b0;
    end else begin
      tap1_r <= issue_s;
      pad1_r <= issue_s && !in_bounds_s;
      vld1_r <= issue_s || gap_slot_s;
      tap2_r <= tap1_r;
      pad2_r <= pad1_r;
      vld2_r <= vld1_r;
    end
  end

  // Activation and enable to the MAC array; pads and clear slots give zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      layer_en_o <= 1'b0;
      ifm_o      <= '0;
    end else begin
      layer_en_o <= vld2_r;
      if (tap2_r && !pad2_r) begin
        ifm_o <= ram_data_i;
      end else begin
        ifm_o <= '0;
      end
    end
  end

  // Handshake to the layer controller: busy from start, done after drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      busy_o <= (state_next != IDLE);
      done_o <= (state_r == DONE);
    end
  end

endmodule

// File: tb/tb_fire_expand3_ifm_reader.sv
// Scoreboard bench for the feature-map reader on a small 4x4x2 frame.
module tb_fire_expand3_ifm_reader;

  localparam int W_IN      = 4;
  localparam int CHIN      = 2;
  localparam int KD        = 3;
  localparam int WIDTH     = 16;
  localparam int GAP       = 1;
  localparam int ADDR_W    = $clog2(W_IN * W_IN * CHIN);
  localparam int DEPTH     = W_IN * W_IN * CHIN;
  localparam int PIX_CYC   = KD * KD * CHIN + GAP;
  localparam int FRAME_LEN = W_IN * W_IN * PIX_CYC;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic              ram_rd_en_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [WIDTH-1:0]  ram_data_i = '0;
  logic              layer_en_o;
  logic [WIDTH-1:0]  ifm_o;
  logic              busy_o;
  logic              done_o;

  logic [WIDTH-1:0] mem [DEPTH];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int exp_first = -1;
  int done_count = 0;
  int exp_addr_q[$];
  int exp_ifm_q[$];

  fire_expand3_ifm_reader #(
    .W_IN       (W_IN),
    .CHIN       (CHIN),
    .KERNEL_DIM (KD),
    .WIDTH      (WIDTH),
    .GAP_CYCLES (GAP),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .ram_rd_en_o (ram_rd_en_o),
    .ram_addr_o  (ram_addr_o),
    .ram_data_i  (ram_data_i),
    .layer_en_o  (layer_en_o),
    .ifm_o       (ifm_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM, one cycle read latency.
  always @(posedge clk) begin
    if (ram_rd_en_o) ram_data_i <= mem[ram_addr_o];
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: expected read addresses and activations for a whole frame.
  task automatic push_frame();
    exp_addr_q.delete();
    exp_ifm_q.delete();
    for (int oy = 0; oy < W_IN; oy++) begin
      for (int ox = 0; ox < W_IN; ox++) begin
        for (int ky = 0; ky < KD; ky++) begin
          for (int kx = 0; kx < KD; kx++) begin
            for (int ch = 0; ch < CHIN; ch++) begin
              int iy, ix, a;
              iy = oy + ky - 1;
              ix = ox + kx - 1;
              if (iy >= 0 && iy < W_IN && ix >= 0 && ix < W_IN) begin
                a = (iy * W_IN + ix) * CHIN + ch;
                exp_addr_q.push_back(a);
                exp_ifm_q.push_back(int'(mem[a]));
              end else begin
                exp_ifm_q.push_back(0);
              end
            end
          end
        end
        for (int g = 0; g < GAP; g++) exp_ifm_q.push_back(0);
      end
    end
  endtask

  task automatic start_frame();
    push_frame();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    exp_first = cyc + 2;
    check("busy_after_start", busy_o, 1);
  endtask

  task automatic wait_done(input int budget);
    int k;
    bit seen;
    k = 0;
    seen = 1'b0;
    while (!seen && k < budget) begin
      @(posedge clk); #1;
      k++;
      if (done_o) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    check("addr_queue_drained", exp_addr_q.size(), 0);
    check("ifm_queue_drained", exp_ifm_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("done_pulse_count", done_count, 1);
  endtask

  // Monitor: compares every DUT output slot against the scoreboard queues.
  initial begin : monitor
    bit le_prev;
    int run_len;
    le_prev = 1'b0;
    run_len = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("rst_rd_en", ram_rd_en_o, 0);
        check("rst_addr", ram_addr_o, 0);
        check("rst_ifm", ifm_o, 0);
        check("rst_layer_en", layer_en_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        le_prev = 1'b0;
        run_len = 0;
      end else begin
        if (ram_rd_en_o) begin
          if (exp_addr_q.size() == 0) check("addr_unexpected", ram_addr_o, -1);
          else check("ram_addr", ram_addr_o, exp_addr_q.pop_front());
        end
        if (layer_en_o) begin
          if (!le_prev) check("layer_en_rise_cycle", cyc, exp_first);
          check("busy_while_en", busy_o, 1);
          if (exp_ifm_q.size() == 0) check("ifm_unexpected", ifm_o, -1);
          else check("ifm", ifm_o, exp_ifm_q.pop_front());
          run_len++;
        end else begin
          check("ifm_idle_zero", ifm_o, 0);
          if (le_prev) begin
            check("layer_en_run_len", run_len, FRAME_LEN);
            check("done_after_fall", done_o, 1);
            check("busy_fall_with_done", busy_o, 0);
          end else begin
            check("done_quiet", done_o, 0);
          end
          run_len = 0;
        end
        if (done_o) done_count++;
        le_prev = layer_en_o;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, actual running required finished");
    $fatal(1);
  end

  // Stimulus sequence.
  initial begin : driver
    int abort_at;
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom_range(1, 65535));
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Frame 1: random RAM, a stray start pulse in the middle of the frame.
    done_count = 0;
    start_frame();
    repeat (100) @(posedge clk);
    #1 start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    wait_done(FRAME_LEN + 20);

    // Frame 2: RAM content equals its address.
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i);
    repeat ($urandom_range(1, 5)) @(posedge clk);
    #1;
    done_count = 0;
    start_frame();
    wait_done(FRAME_LEN + 20);

    // Frame 3: aborted by a one-cycle reset pulse; no done may follow.
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom_range(1, 65535));
    done_count = 0;
    start_frame();
    abort_at = $urandom_range(20, FRAME_LEN - 20);
    repeat (abort_at) @(posedge clk);
    #1 rst = 1'b0;
    exp_addr_q.delete();
    exp_ifm_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", done_count, 0);
    check("abort_idle_layer_en", layer_en_o, 0);
    check("abort_idle_busy", busy_o, 0);

    // Frame 4: fresh start after the abort restarts from pixel (0,0).
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom_range(1, 65535));
    done_count = 0;
    start_frame();
    wait_done(FRAME_LEN + 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
